// File: rtl/alu_ctrl_stage_if.sv
// Decode-to-execute control bundle between the decoder/hazard logic and the ALU control stage.
interface alu_ctrl_stage_if;
   logic       valid_i;
   logic [2:0] aluop_i;
   logic [5:0] funct_i;
   logic [4:0] shamt_i;
   logic       stall_i;
   logic       flush_i;
   logic [3:0] ctrl_o;
   logic [4:0] shamt_o;
   logic       valid_o;
   logic       illegal_o;
   logic       busy_o;

   modport slave (
      input  valid_i, aluop_i, funct_i, shamt_i, stall_i, flush_i,
      output ctrl_o, shamt_o, valid_o, illegal_o, busy_o
   );

   modport master (
      output valid_i, aluop_i, funct_i, shamt_i, stall_i, flush_i,
      input  ctrl_o, shamt_o, valid_o, illegal_o, busy_o
   );
endinterface

// File: rtl/alu_ctrl_stage.sv
// ID/EX ALU control stage: decodes aluop/funct into ALU control and shift amount, with stall/flush.
// Define ALU_CTRL_MULT_EN to decode mult and sequence its MULT_LAT-cycle occupancy.
module alu_ctrl_stage #(
   parameter int MULT_LAT = 3
) (
   input  logic             clk_i,
   input  logic             rst_i,
   alu_ctrl_stage_if.slave  bus
);

   if (MULT_LAT < 1 || MULT_LAT > 15) begin : g_lat_check
      $error("MULT_LAT must be 1..15");
   end

   logic [3:0] w_ctrl;
   logic [4:0] w_shamt;
   logic       w_ill;
   logic       w_sll;
   logic       w_mult;
   logic       w_busy;
   logic       w_hold;

   logic [3:0] r_ctrl_p1;
   logic [4:0] r_shamt_p1;
   logic       r_ill_p1;
   logic       r_vld_p1;

   // Decode: illegal encodings fall through with ctrl 0000 and the illegal flag set
   always_comb begin
      w_ctrl = 4'b0000;
      w_ill  = 1'b0;
      w_sll  = 1'b0;
      w_mult = 1'b0;
      case (bus.aluop_i)
         3'b000: w_ctrl = 4'b0010;
         3'b001: w_ctrl = 4'b0110;
         3'b010: begin
            case (bus.funct_i)
               6'b100000: w_ctrl = 4'b0010;
               6'b100010: w_ctrl = 4'b0110;
               6'b100100: w_ctrl = 4'b0000;
               6'b100101: w_ctrl = 4'b0001;
               6'b100111: w_ctrl = 4'b1100;
               6'b101010: w_ctrl = 4'b0111;
               6'b000000: begin
                  w_ctrl = 4'b0101;
                  w_sll  = 1'b1;
               end
               6'b000110: w_ctrl = 4'b1111;
`ifdef ALU_CTRL_MULT_EN
               6'b011000: begin
                  w_ctrl = 4'b0011;
                  w_mult = 1'b1;
               end
`endif
               default:   w_ill  = 1'b1;
            endcase
         end
         3'b011: w_ctrl = 4'b0111;
         3'b100: w_ctrl = 4'b0100;
         3'b101: w_ctrl = 4'b0001;
         3'b110: w_ctrl = 4'b0000;
         default: w_ill = 1'b1;
      endcase
   end

   assign w_shamt = w_sll ? bus.shamt_i : 5'd0;

`ifdef ALU_CTRL_MULT_EN
   localparam logic [3:0] CNT_LOAD = 4'(MULT_LAT - 1);
   logic [3:0] r_cnt;

   // Occupancy counter keeps running under stall so the multiply still completes
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_cnt <= 4'd0;
      end else if (bus.flush_i) begin
         r_cnt <= 4'd0;
      end else if (r_cnt != 4'd0) begin
         r_cnt <= r_cnt - 4'd1;
      end else if (!bus.stall_i && bus.valid_i && w_mult) begin
         r_cnt <= CNT_LOAD;
      end
   end

   assign w_busy = (r_cnt != 4'd0);
`else
   assign w_busy = 1'b0;
`endif

   assign w_hold = bus.stall_i | w_busy;

   // ID/EX boundary register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_ctrl_p1  <= 4'd0;
         r_shamt_p1 <= 5'd0;
         r_ill_p1   <= 1'b0;
         r_vld_p1   <= 1'b0;
      end else if (bus.flush_i) begin
         r_ctrl_p1  <= 4'd0;
         r_shamt_p1 <= 5'd0;
         r_ill_p1   <= 1'b0;
         r_vld_p1   <= 1'b0;
      end else if (!w_hold) begin
         r_vld_p1   <= bus.valid_i;
         r_ctrl_p1  <= bus.valid_i ? w_ctrl  : 4'd0;
         r_shamt_p1 <= bus.valid_i ? w_shamt : 5'd0;
         r_ill_p1   <= bus.valid_i & w_ill;
      end
   end

   assign bus.ctrl_o    = r_ctrl_p1;
   assign bus.shamt_o   = r_shamt_p1;
   assign bus.illegal_o = r_ill_p1;
   assign bus.valid_o   = r_vld_p1 & ~w_busy;
   assign bus.busy_o    = w_busy;

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Directed bench for alu_ctrl_stage: decode table plus stall/flush, mult occupancy and reset sequences.
module tb_alu_ctrl_stage;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_bad;

   alu_ctrl_stage_if bus ();

   alu_ctrl_stage #(.MULT_LAT(3)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       valid;
      logic [2:0] aluop;
      logic [5:0] funct;
      logic [4:0] shamt;
      logic [3:0] e_ctrl;
      logic [4:0] e_shamt;
      logic       e_valid;
      logic       e_ill;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic v, logic [2:0] op, logic [5:0] fn, logic [4:0] sh,
                               logic [3:0] ec, logic [4:0] es, logic ev, logic ei);
      vec_t t;
      t.valid = v;  t.aluop = op;  t.funct = fn;  t.shamt = sh;
      t.e_ctrl = ec; t.e_shamt = es; t.e_valid = ev; t.e_ill = ei;
      return t;
   endfunction

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chk_all(input string nm, input logic [3:0] c, input logic [4:0] s,
                          input logic v, input logic i, input logic b);
      chk({nm, ".ctrl"},    8'(bus.ctrl_o),    8'(c));
      chk({nm, ".shamt"},   8'(bus.shamt_o),   8'(s));
      chk({nm, ".valid"},   8'(bus.valid_o),   8'(v));
      chk({nm, ".illegal"}, 8'(bus.illegal_o), 8'(i));
      chk({nm, ".busy"},    8'(bus.busy_o),    8'(b));
   endtask

   task automatic drive(input logic v, input logic [2:0] op, input logic [5:0] fn, input logic [4:0] sh);
      bus.valid_i = v;
      bus.aluop_i = op;
      bus.funct_i = fn;
      bus.shamt_i = sh;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_vec = 0;
      n_bad = 0;
      rst = 1'b1;
      bus.stall_i = 1'b0;
      bus.flush_i = 1'b0;
      drive(1'b0, 3'b000, 6'd0, 5'd0);

      vecs.push_back(mk(1, 3'b010, 6'b100010, 5'd0, 4'b0110, 5'd0, 1, 0));
      vecs.push_back(mk(1, 3'b010, 6'b000000, 5'd7, 4'b0101, 5'd7, 1, 0));
      vecs.push_back(mk(1, 3'b100, 6'b000000, 5'd7, 4'b0100, 5'd0, 1, 0));
      vecs.push_back(mk(1, 3'b000, 6'b101010, 5'd3, 4'b0010, 5'd0, 1, 0));
      vecs.push_back(mk(1, 3'b001, 6'b000000, 5'd0, 4'b0110, 5'd0, 1, 0));
      vecs.push_back(mk(1, 3'b011, 6'b000000, 5'd0, 4'b0111, 5'd0, 1, 0));
      vecs.push_back(mk(1, 3'b101, 6'b000000, 5'd0, 4'b0001, 5'd0, 1, 0));
      vecs.push_back(mk(1, 3'b110, 6'b000000, 5'd0, 4'b0000, 5'd0, 1, 0));
      vecs.push_back(mk(1, 3'b111, 6'b100000, 5'd4, 4'b0000, 5'd0, 1, 1));
      vecs.push_back(mk(1, 3'b010, 6'b100000, 5'd0, 4'b0010, 5'd0, 1, 0));
      vecs.push_back(mk(1, 3'b010, 6'b100100, 5'd0, 4'b0000, 5'd0, 1, 0));
      vecs.push_back(mk(1, 3'b010, 6'b100101, 5'd0, 4'b0001, 5'd0, 1, 0));
      vecs.push_back(mk(1, 3'b010, 6'b100111, 5'd0, 4'b1100, 5'd0, 1, 0));
      vecs.push_back(mk(1, 3'b010, 6'b101010, 5'd9, 4'b0111, 5'd0, 1, 0));
      vecs.push_back(mk(1, 3'b010, 6'b000110, 5'd3, 4'b1111, 5'd0, 1, 0));
      vecs.push_back(mk(1, 3'b010, 6'b111111, 5'd5, 4'b0000, 5'd0, 1, 1));
      vecs.push_back(mk(0, 3'b010, 6'b000000, 5'd7, 4'b0000, 5'd0, 0, 0));
`ifndef ALU_CTRL_MULT_EN
      vecs.push_back(mk(1, 3'b010, 6'b011000, 5'd0, 4'b0000, 5'd0, 1, 1));
`endif

      // Reset state
      #2;
      chk_all("reset", 4'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      rst = 1'b0;

      foreach (vecs[i]) begin
         drive(vecs[i].valid, vecs[i].aluop, vecs[i].funct, vecs[i].shamt);
         tick();
         chk_all($sformatf("vec%0d", i), vecs[i].e_ctrl, vecs[i].e_shamt,
                 vecs[i].e_valid, vecs[i].e_ill, 1'b0);
      end

      // Stall holds an or while the decoder input changes; flush beats stall
      drive(1'b1, 3'b101, 6'd0, 5'd0);
      tick();
      chk_all("or_load", 4'b0001, 5'd0, 1'b1, 1'b0, 1'b0);
      bus.stall_i = 1'b1;
      drive(1'b1, 3'b000, 6'd0, 5'd0);
      tick();
      chk_all("stall1", 4'b0001, 5'd0, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 3'b011, 6'd0, 5'd0);
      tick();
      chk_all("stall2", 4'b0001, 5'd0, 1'b1, 1'b0, 1'b0);
      bus.flush_i = 1'b1;
      tick();
      chk_all("flush", 4'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      bus.flush_i = 1'b0;
      bus.stall_i = 1'b0;

`ifdef ALU_CTRL_MULT_EN
      // Mult occupancy with the next add held upstream
      drive(1'b1, 3'b010, 6'b011000, 5'd0);
      tick();
      chk_all("mult_n0", 4'b0011, 5'd0, 1'b0, 1'b0, 1'b1);
      drive(1'b1, 3'b000, 6'd0, 5'd0);
      tick();
      chk_all("mult_n1", 4'b0011, 5'd0, 1'b0, 1'b0, 1'b1);
      tick();
      chk_all("mult_n2", 4'b0011, 5'd0, 1'b1, 1'b0, 1'b0);
      tick();
      chk_all("mult_next_add", 4'b0010, 5'd0, 1'b1, 1'b0, 1'b0);

      // Stall during busy does not freeze the counter
      drive(1'b1, 3'b010, 6'b011000, 5'd0);
      tick();
      bus.stall_i = 1'b1;
      tick();
      chk_all("mult_stall_n1", 4'b0011, 5'd0, 1'b0, 1'b0, 1'b1);
      tick();
      chk_all("mult_stall_n2", 4'b0011, 5'd0, 1'b1, 1'b0, 1'b0);
      bus.stall_i = 1'b0;

      // Flush during busy clears the counter
      drive(1'b1, 3'b010, 6'b011000, 5'd0);
      tick();
      bus.flush_i = 1'b1;
      tick();
      chk_all("mult_flush", 4'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      bus.flush_i = 1'b0;
`else
      drive(1'b1, 3'b010, 6'b011000, 5'd0);
      tick();
      chk_all("mult_off", 4'd0, 5'd0, 1'b1, 1'b1, 1'b0);
      drive(1'b1, 3'b000, 6'd0, 5'd0);
      tick();
      chk_all("mult_off_next", 4'b0010, 5'd0, 1'b1, 1'b0, 1'b0);
`endif

      // Asynchronous reset one cycle after a mult loads
      drive(1'b1, 3'b010, 6'b011000, 5'd0);
      tick();
      drive(1'b1, 3'b000, 6'd0, 5'd0);
      tick();
      rst = 1'b1;
      #1;
      chk_all("rst_mid_mult", 4'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      #1;
      rst = 1'b0;
      drive(1'b1, 3'b000, 6'd0, 5'd0);
      tick();
      chk_all("post_rst_add", 4'b0010, 5'd0, 1'b1, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/alu_ctrl_stage.md
# alu_ctrl_stage

Decode-to-execute control stage for the pipelined CPU: turns the main decoder's 3-bit ALU operation class and the instruction funct/shamt fields into the 4-bit ALU control code and shift amount that the ALU consumes. It registers them into the ID/EX boundary with stall and flush handling. It also sequences multi-cycle multiply occupancy with a busy counter.

## Interface
- MULT_LAT, 3: cycles a mult occupies the stage (1..15); 1 means single-cycle, busy never asserted.
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- valid_i  input  1  decode-stage instruction present.
- aluop_i  input  3  operation class from main decoder.
- funct_i  input  6  instruction[5:0].
- shamt_i  input  5  instruction[10:6].
- stall_i  input  1  hold stage contents (hazard unit).
- flush_i  input  1  replace stage contents with bubble.
- ctrl_o  output  4  ALU control code.
- shamt_o  output  5  shift amount to ALU.
- valid_o  output  1  EX holds an instruction whose result is final this cycle.
- illegal_o  output  1  registered: loaded instruction had undecodable aluop/funct.
- busy_o  output  1  multi-cycle op in progress; upstream must hold.

## Operation
- aluop_i map: 000 add→0010; 001 sub→0110; 010 R-type (funct); 011 slti→0111; 100 lui→0100; 101 ori→0001; 110 andi→0000; 111 illegal.
- R-type funct map: 100000 add→0010; 100010 sub→0110; 100100 and→0000; 100101 or→0001; 100111 nor→1100; 101010 slt→0111; 000000 sll→0101; 000110 srlv→1111; 011000 mult→0011; any other funct illegal.
- Illegal: ctrl 0000, shamt 0, illegal_o=1, valid_o=1 (exception logic downstream decides).
- shamt_o = shamt_i only for sll; 0 otherwise.
- Per-edge priority: rst_i > flush_i > hold (stall_i or busy_o) > load.
- Load: stage captures decoded ctrl/shamt/illegal and valid_i. If valid_i=0, stage loads bubble (ctrl 0000, shamt 0, valid 0, illegal 0).
- Bubble: all outputs 0.
- Mult load with MULT_LAT>1: counter ← MULT_LAT−1; ctrl_o=0011 held for the whole occupancy; valid_o=0 while counter≠0; counter decrements each edge; valid_o=1 on the cycle the counter reads 0.
- busy_o = (counter≠0), combinational from the counter.
- flush_i clears stage and counter regardless of busy_o.
- stall_i during busy: counter still decrements (multiply progresses); stage contents held.

## Timing
- Reset (async assert, sync-safe release): ctrl_o=0000, shamt_o=0, valid_o=0, illegal_o=0, busy_o=0, counter=0.
- Latency: decode inputs at edge N → outputs valid after edge N, one cycle.
- Mult, MULT_LAT=3, loaded at edge N:
  - After edge N: busy_o=1, valid_o=0.
  - After edge N+1: busy_o=1, valid_o=0.
  - After edge N+2: busy_o=0, valid_o=1.
  - Edge N+3 may load the next instruction.
- Inputs presented while busy_o=1 are ignored; the upstream stage must hold them.
- Reset mid-mult: counter and outputs zero immediately and asynchronously.

## Configuration
- ALU_CTRL_MULT_EN defined: funct 011000 decodes to mult (0011) with MULT_LAT occupancy and busy counter.
- ALU_CTRL_MULT_EN undefined:
  - funct 011000 is illegal.
  - Counter logic is absent; busy_o is tied to 0.
  - MULT_LAT is ignored.

## Test plan
- Reset release, then valid_i=1, aluop 010, funct 100010 → after next edge ctrl_o=0110, valid_o=1, illegal_o=0, busy_o=0.
- aluop 010, funct 000000, shamt_i=7 → ctrl_o=0101, shamt_o=7; then aluop 100 → ctrl_o=0100, shamt_o=0.
- Mult (macro on, MULT_LAT=3) at edge N, with a new add presented at N+1 → busy_o 1,1,0 and valid_o 0,0,1 over edges N..N+2; add (0010) appears after N+3.
- stall_i=1 for 2 cycles holding an or (0001) while aluop changes → ctrl_o stays 0001, valid_o=1; flush_i with stall_i → bubble next edge.
- aluop 010, funct 111111 → illegal_o=1, ctrl_o=0000. Repeat funct 011000 with macro off → illegal_o=1, busy_o=0.
- Assert rst_i one cycle after a mult loads → outputs and busy_o 0 before the next edge; the following add decodes normally.
